// File: rtl/softmax_pkg.sv
// Shared widths, the Q8.8 unit constant and the FSM state type for the softmax normalizer.
package softmax_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned FRAC  = 8;

  localparam logic [15:0] ONE_Q88 = 16'h0100;

  typedef enum logic [1:0] {
    S_LOAD,
    S_DIV,
    S_OUT
  } state_t;

endpackage

// File: rtl/softmax_div.sv
// Restoring unsigned divider: one quotient bit per cycle, quotient truncated.
// done pulses for one cycle after the last iteration.
module softmax_div #(
  parameter int unsigned DVD_W = 24,
  parameter int unsigned DVS_W = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  logic [CNT_W-1:0] cnt;
  logic             running;
  logic [DVS_W:0]   trial;
  logic             fits;

  // Quotient register doubles as the dividend shift register.
  always_comb begin
    trial = {rem, quotient[DVD_W-1]};
    fits  = (trial >= {1'b0, dvs});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running  <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        running  <= 1'b1;
        cnt      <= CNT_W'(DVD_W);
        rem      <= '0;
        dvs      <= divisor;
        quotient <= dividend;
      end else if (running) begin
        rem      <= fits ? DVS_W'(trial - {1'b0, dvs}) : DVS_W'(trial);
        quotient <= {quotient[DVD_W-2:0], fits};
        cnt      <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/softmax_norm.sv
// Softmax normalizer: buffers N exp() samples and their sum, then emits each
// sample divided by the sum as a Q8.8 probability, one element at a time.
module softmax_norm #(
  parameter int unsigned WIDTH = softmax_pkg::WIDTH,
  parameter int unsigned FRAC  = softmax_pkg::FRAC,
  parameter int unsigned N     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  import softmax_pkg::*;

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned SUM_W = WIDTH + IDX_W;
  localparam int unsigned DVD_W = WIDTH + FRAC;

  state_t           state, state_next;
  logic [IDX_W-1:0] idx, idx_next, idx_inc;
  logic [SUM_W-1:0] sum, sum_next;
  logic [WIDTH-1:0] sample_buf [N];
  logic [WIDTH-1:0] out_data_next;
  logic             out_last_next;
  logic             buf_we;
  logic             div_start;
  logic             div_done;
  logic [DVD_W-1:0] div_dividend;
  logic [SUM_W-1:0] div_divisor;
  logic [DVD_W-1:0] div_quotient;
  logic             at_last;

  assign idx_inc = idx + 1'b1;
  assign at_last = (idx == IDX_W'(N - 1));

  // Next-state, datapath updates and divider launch on every entry into S_DIV.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    sum_next      = sum;
    out_data_next = out_data;
    out_last_next = out_last;
    buf_we        = 1'b0;
    div_start     = 1'b0;
    div_dividend  = '0;
    div_divisor   = '0;
    unique case (state)
      S_LOAD: begin
        if (in_valid) begin
          buf_we   = 1'b1;
          sum_next = sum + SUM_W'(in_data);
          idx_next = idx_inc;
          if (at_last) begin
            state_next   = S_DIV;
            idx_next     = '0;
            div_dividend = DVD_W'(sample_buf[0]) << FRAC;
            div_divisor  = sum_next;
            div_start    = (sum_next != '0);
          end
        end
      end
      S_DIV: begin
        // A zero sum skips the divider entirely and yields a zero probability.
        if (sum == '0) begin
          state_next    = S_OUT;
          out_data_next = '0;
          out_last_next = at_last;
        end else if (div_done) begin
          state_next    = S_OUT;
          out_data_next = (div_quotient > DVD_W'(ONE_Q88)) ? WIDTH'(ONE_Q88)
                                                           : WIDTH'(div_quotient);
          out_last_next = at_last;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_last_next = 1'b0;
          if (at_last) begin
            state_next = S_LOAD;
            idx_next   = '0;
            sum_next   = '0;
          end else begin
            state_next   = S_DIV;
            idx_next     = idx_inc;
            div_dividend = DVD_W'(sample_buf[idx_inc]) << FRAC;
            div_divisor  = sum;
            div_start    = (sum != '0);
          end
        end
      end
      default: state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOAD;
      idx       <= '0;
      sum       <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      sum       <= sum_next;
      out_data  <= out_data_next;
      out_last  <= out_last_next;
      out_valid <= (state_next == S_OUT);
      busy      <= (state_next != S_LOAD);
      in_ready  <= (state_next == S_LOAD);
    end
  end

  // Sample storage carries no reset; it is always rewritten before use.
  always_ff @(posedge clk) begin
    if (buf_we) sample_buf[idx] <= in_data;
  end

  softmax_div #(
    .DVD_W(DVD_W),
    .DVS_W(SUM_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend(div_dividend),
    .divisor (div_divisor),
    .done    (div_done),
    .quotient(div_quotient)
  );

endmodule

// File: tb/tb_softmax_norm.sv
// Randomized bench for softmax_norm: each vector is compared against a plain
// arithmetic softmax-normalization model (x*256/sum, saturated at 1.0).
module tb_softmax_norm;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned FRAC  = 8;
  localparam int unsigned N     = 8;
  localparam int          LAT   = WIDTH + FRAC + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;

  int checks;
  int errors;

  logic [WIDTH-1:0] vec      [N];
  logic [WIDTH-1:0] got_data [N];
  logic             got_last [N];
  int               got_lat  [N];
  int               extra_acc;
  int               stall_bad;
  bit               hold_valid;

  softmax_norm #(
    .WIDTH(WIDTH),
    .FRAC (FRAC),
    .N    (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] model_out(input int i);
    longint s = 0;
    longint q;
    for (int k = 0; k < N; k++) s += longint'(vec[k]);
    if (s == 0) return '0;
    q = (longint'(vec[i]) * (longint'(1) << FRAC)) / s;
    if (q > 256) q = 256;
    return WIDTH'(q);
  endfunction

  function automatic int model_lat();
    longint s = 0;
    for (int k = 0; k < N; k++) s += longint'(vec[k]);
    return (s == 0) ? 1 : LAT;
  endfunction

  task automatic send_vec();
    for (int i = 0; i < N; i++) begin
      int n = 0;
      in_data  = vec[i];
      in_valid = 1'b1;
      while (!in_ready && n < 300) begin
        @(posedge clk); #1; n++;
      end
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL send_timeout elem %0d in_ready got 0 expected 1", i);
      end
      @(posedge clk); #1;
    end
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic get_out(input int i, input int stall);
    int n = 0;
    while (!out_valid && n < 300) begin
      if (in_valid && in_ready) extra_acc++;
      @(posedge clk); #1; n++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_timeout elem %0d out_valid got 0 expected 1", i);
    end
    got_lat[i]  = n;
    got_data[i] = out_data;
    got_last[i] = out_last;
    for (int c = 0; c < stall; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_data !== got_data[i] ||
          out_last !== got_last[i] || in_ready !== 1'b0) stall_bad++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input int stall_elem, input int stall_len);
    send_vec();
    for (int i = 0; i < N; i++) get_out(i, (i == stall_elem) ? stall_len : 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h l=%b b=%b r=%b expected v=0 d=0000 l=0 b=0 r=1",
               out_valid, out_data, out_last, busy, in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // pat 0: all 1.0, 1: one-hot 2.0, 2: all 0xFFFF, 3: all zero, >=4: random
  task automatic test_patterns(input int pat);
    for (int k = 0; k < N; k++) begin
      case (pat)
        0:       vec[k] = 16'h0100;
        1:       vec[k] = (k == 0) ? 16'h0200 : 16'h0000;
        2:       vec[k] = 16'hFFFF;
        3:       vec[k] = 16'h0000;
        default: vec[k] = (pat % 2 == 1) ? WIDTH'($urandom_range(1, 65535))
                                         : WIDTH'($urandom_range(1, 255));
      endcase
    end
    extra_acc = 0;
    run_vec(-1, 0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_data[i] !== model_out(i)) begin
        errors++;
        $display("FAIL pat%0d_data[%0d] got %h expected %h", pat, i, got_data[i], model_out(i));
      end
      checks++;
      if (got_last[i] !== (i == N - 1)) begin
        errors++;
        $display("FAIL pat%0d_last[%0d] got %b expected %b", pat, i, got_last[i], i == N - 1);
      end
      checks++;
      if (got_lat[i] != model_lat()) begin
        errors++;
        $display("FAIL pat%0d_latency[%0d] got %0d expected %0d", pat, i, got_lat[i], model_lat());
      end
    end
    checks++;
    if (extra_acc != 0) begin
      errors++;
      $display("FAIL pat%0d_busy_accept got %0d expected 0", pat, extra_acc);
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < N; k++) vec[k] = WIDTH'($urandom_range(1, 65535));
    stall_bad = 0;
    run_vec(2, 10);
    checks++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL stall_stability got %0d unstable cycles expected 0", stall_bad);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_data[i] !== model_out(i) || got_last[i] !== (i == N - 1)) begin
        errors++;
        $display("FAIL stall_data[%0d] got %h/%b expected %h/%b", i, got_data[i], got_last[i],
                 model_out(i), i == N - 1);
      end
    end
  endtask

  task automatic test_reset_mid_divide();
    for (int k = 0; k < N; k++) vec[k] = WIDTH'($urandom_range(1, 65535));
    send_vec();
    for (int i = 0; i < 4; i++) get_out(i, 0);
    repeat (10) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_divide_state got busy=%b valid=%b expected busy=1 valid=0", busy, out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_state got v=%b d=%h l=%b b=%b r=%b expected v=0 d=0000 l=0 b=0 r=1",
               out_valid, out_data, out_last, busy, in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) vec[k] = 16'h0100;
    run_vec(-1, 0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_data[i] !== 16'h0020 || got_last[i] !== (i == N - 1)) begin
        errors++;
        $display("FAIL post_reset_data[%0d] got %h/%b expected 0020/%b", i, got_data[i],
                 got_last[i], i == N - 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    hold_valid = 1'b1;
    extra_acc  = 0;
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < N; k++) vec[k] = WIDTH'($urandom_range(1, 65535));
      run_vec(-1, 0);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (got_data[i] !== model_out(i) || got_lat[i] != LAT) begin
          errors++;
          $display("FAIL b2b_v%0d[%0d] got %h lat %0d expected %h lat %0d", v, i, got_data[i],
                   got_lat[i], model_out(i), LAT);
        end
      end
    end
    hold_valid = 1'b0;
    in_valid   = 1'b0;
    checks++;
    if (extra_acc != 0) begin
      errors++;
      $display("FAIL b2b_busy_accept got %0d expected 0", extra_acc);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    hold_valid = 1'b0;
    extra_acc  = 0;
    stall_bad  = 0;
    test_reset();
    for (int p = 0; p < 8; p++) test_patterns(p);
    test_stall();
    test_reset_mid_divide();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/softmax_norm.md
SOFTMAX_NORM -- requirements
Module: softmax_norm

Interface
REQ-001 SHALL expose parameter WIDTH, default 16, meaning data width of the Q8.8 sample.
REQ-002 SHALL expose parameter FRAC, default 8, meaning number of fractional bits.
REQ-003 SHALL expose parameter N, default 8, meaning vector length (power of two, 2..64).
REQ-004 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream exp sample valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  exp(x) sample, unsigned Q8.8 (0x0001..0xFFFF).
REQ-009 SHALL have port out_valid  output  1  normalized sample valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the output.
REQ-011 SHALL have port out_data  output  WIDTH  normalized probability, unsigned Q8.8, at most 0x0100.
REQ-012 SHALL have port out_last  output  1  marks element N-1 of the vector.
REQ-013 SHALL have port busy  output  1  high whenever the state is not S_LOAD.

Function
REQ-014 SHALL implement states S_LOAD, S_DIV, S_OUT.
REQ-015 Transfers SHALL occur only on valid&&ready; in_ready SHALL equal (state==S_LOAD).
REQ-016 In S_LOAD, each accepted sample SHALL be stored to buf[idx] and added to sum (width WIDTH+log2(N), no overflow possible), then idx increments.
REQ-017 On acceptance with idx==N-1, the block SHALL move to S_DIV with idx=0.
REQ-018 On S_DIV entry, the block SHALL start the divider with dividend = buf[idx] << FRAC and divisor = sum.
REQ-019 The divider SHALL perform WIDTH+FRAC restoring iterations, one per cycle, with a truncated quotient.
REQ-020 When the divider signals done, the quotient SHALL be saturated to 0x0100 and registered into out_data, and the block SHALL move to S_OUT the next cycle.
REQ-021 If sum==0, the divider SHALL be bypassed, out_data SHALL be 0, and S_DIV SHALL last exactly 1 cycle.
REQ-022 In S_OUT, out_valid SHALL be 1, and out_data and out_last SHALL stay stable until out_ready.
REQ-023 On an output handshake with idx==N-1, the block SHALL clear sum and idx and return to S_LOAD; otherwise it SHALL increment idx and return to S_DIV.
REQ-024 out_valid SHALL be 0 in S_LOAD and S_DIV.
REQ-025 Latency from entering S_DIV to out_valid SHALL be WIDTH+FRAC+1 cycles (24+1 at defaults), or 1 cycle when sum==0.
REQ-026 A new vector SHALL NOT be accepted until the last output of the previous vector has been handshaken; no overlap.
REQ-027 in_valid while busy SHALL be ignored, and no sample SHALL be lost, because in_ready is low.

Reset
REQ-028 While rst is high at a clock edge: state SHALL be S_LOAD, idx=0, sum=0, out_valid=0, out_data=0, out_last=0, busy=0, and the divider SHALL be idle.
REQ-029 Reset asserted mid-load, mid-divide or mid-output SHALL abandon the vector; the next vector after reset SHALL be processed correctly.
REQ-030 buf contents SHALL NOT require reset.

Structure
REQ-031 Package softmax_pkg SHALL hold WIDTH, FRAC, ONE_Q88=0x0100 and the state enum type.
REQ-032 The divider SHALL be a separate sub-module softmax_div.
- Ports: clk, rst, start, dividend, divisor, done, quotient.
- done is a 1-cycle pulse.
REQ-033 Top-level RTL and divider together SHALL fit in 120-400 lines.

Verification (N=8 at defaults)
REQ-034 Feed eight 0x0100 samples -> eight outputs of 0x0020; out_last set only on the 8th.
REQ-035 Feed 0x0200 followed by seven 0x0000 -> outputs 0x0100 then seven 0x0000.
REQ-036 Feed eight 0xFFFF samples -> sum 0x7FFF8 and every output 0x0020, with no overflow.
REQ-037 Hold out_ready low for 10 cycles during S_OUT -> out_data/out_last stable and in_ready 0 throughout; the sequence resumes intact.
REQ-038 Pulse rst during the 5th divide of a vector -> all outputs at reset values next cycle; a following vector of eight 0x0100 -> eight outputs of 0x0020.
REQ-039 Drive in_valid continuously across two vectors -> exactly 8 samples accepted per vector, none while busy; measured latency is 25 cycles per element.
